// File: rtl/dp_seq_ctrl.sv
// dp_seq_ctrl: command-driven sequencer for the dp32 SIMD dot-product datapath.
// It takes a command (mode, length N) and streams N operand pairs into dp32 at
// one pair per cycle. It accumulates the dp32 output that matches the mode and
// returns one result through a valid/ready handshake.
// Optional build macro DP_SEQ_SAT_EN: when it is defined, the accumulator
// saturates at all-ones and a sticky overflow flag is ORed into res_err.
module dp_seq_ctrl #(
  parameter int ACC_W = 72,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic [31:0]      dp_a,
  output logic [31:0]      dp_b,
  input  logic [63:0]      dp_mul_int32,
  input  logic [32:0]      dp_sum_int16,
  input  logic [17:0]      dp_sum_int8,
  input  logic [10:0]      dp_sum_int4,
  input  logic [7:0]       dp_sum_int2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_err,
  output logic             busy
);

  // The addend is widened to at least 64 bits so that no dp32 output is truncated.
  localparam int EXT_W = (ACC_W > 64) ? ACC_W : 64;
  localparam logic [LEN_W-1:0] REM_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             stg_v_q, stg_v_d;
  logic [31:0]      dp_a_q, dp_a_d;
  logic [31:0]      dp_b_q, dp_b_d;
  logic             err_q, err_d;
`ifdef DP_SEQ_SAT_EN
  logic             sat_q, sat_d;
  logic [EXT_W:0]   sum_s;
`endif
  logic             cmd_ready_q, cmd_ready_d;
  logic             op_ready_q, op_ready_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;

  logic             cmd_acc_s, op_acc_s, res_hs_s;
  logic [63:0]      sel_s;
  logic [EXT_W-1:0] addend_s;

  assign cmd_ready = cmd_ready_q;
  assign op_ready  = op_ready_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;

  // Next-state logic: handshakes, partial-sum selection, accumulation, sequencing.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    stg_v_d  = stg_v_q;
    dp_a_d   = dp_a_q;
    dp_b_d   = dp_b_q;
    err_d    = err_q;
`ifdef DP_SEQ_SAT_EN
    sat_d    = sat_q;
    sum_s    = {(EXT_W + 1){1'b0}};
`endif

    // The ready registers are high only in the states that own each handshake.
    cmd_acc_s = cmd_ready_q & cmd_valid;
    op_acc_s  = op_ready_q & op_valid;
    res_hs_s  = res_valid_q & res_ready;

    case (mode_q)
      3'd0:    sel_s = {56'd0, dp_sum_int2};
      3'd1:    sel_s = {53'd0, dp_sum_int4};
      3'd2:    sel_s = {46'd0, dp_sum_int8};
      3'd3:    sel_s = {31'd0, dp_sum_int16};
      3'd4:    sel_s = dp_mul_int32;
      default: sel_s = 64'd0;
    endcase
    addend_s = EXT_W'(sel_s);

    // The staged pair was driven into dp32 last cycle, so its result is valid now.
    if (stg_v_q) begin
`ifdef DP_SEQ_SAT_EN
      sum_s = {1'b0, EXT_W'(acc_q)} + {1'b0, addend_s};
      if (|sum_s[EXT_W:ACC_W]) begin
        acc_d = {ACC_W{1'b1}};
        sat_d = 1'b1;
      end else begin
        acc_d = sum_s[ACC_W-1:0];
      end
`else
      acc_d = acc_q + addend_s[ACC_W-1:0];
`endif
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      IDLE: begin
        if (cmd_acc_s) begin
          mode_d = cmd_mode;
          rem_d  = cmd_len;
          acc_d  = {ACC_W{1'b0}};
          err_d  = (cmd_mode > 3'd4);
`ifdef DP_SEQ_SAT_EN
          sat_d  = 1'b0;
`endif
          if ((cmd_mode <= 3'd4) && (cmd_len != {LEN_W{1'b0}})) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        stg_v_d = op_acc_s;
        if (op_acc_s) begin
          dp_a_d = op_a;
          dp_b_d = op_b;
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        stg_v_d = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (res_hs_s) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        stg_v_d = 1'b0;
      end
    endcase

    // The result is presented one cycle after entering DONE and is dropped on the handshake.
    cmd_ready_d = (state_d == IDLE);
    op_ready_d  = (state_d == RUN) && (rem_d != {LEN_W{1'b0}});
    busy_d      = (state_d != IDLE);
    res_valid_d = (state_q == DONE) && !res_hs_s;
    if (res_valid_d) begin
      res_data_d = acc_q;
`ifdef DP_SEQ_SAT_EN
      res_err_d  = err_q | sat_q;
`else
      res_err_d  = err_q;
`endif
    end else begin
      res_data_d = {ACC_W{1'b0}};
      res_err_d  = 1'b0;
    end
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 3'd0;
      rem_q       <= {LEN_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      stg_v_q     <= 1'b0;
      dp_a_q      <= 32'd0;
      dp_b_q      <= 32'd0;
      err_q       <= 1'b0;
`ifdef DP_SEQ_SAT_EN
      sat_q       <= 1'b0;
`endif
      cmd_ready_q <= 1'b1;
      op_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= {ACC_W{1'b0}};
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      stg_v_q     <= stg_v_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      err_q       <= err_d;
`ifdef DP_SEQ_SAT_EN
      sat_q       <= sat_d;
`endif
      cmd_ready_q <= cmd_ready_d;
      op_ready_q  <= op_ready_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// Self-checking bench for dp_seq_ctrl. It contains a dp32 stub and a
// transaction-level reference model that is compared with the DUT every cycle.
module tb_dp_seq_ctrl;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_mode;
  logic [15:0] cmd_len;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b, dp_a, dp_b;
  logic [63:0] dp_mul_int32;
  logic [32:0] dp_sum_int16;
  logic [17:0] dp_sum_int8;
  logic [10:0] dp_sum_int4;
  logic [7:0]  dp_sum_int2;
  logic        res_valid, res_ready, res_err, busy;
  logic [71:0] res_data;

  int total = 0;
  int bad   = 0;

  // dp32 stub: either fixed values or simple functions of the staged operands
  bit          fixed_en = 0;
  logic [63:0] fixed_val = 64'd0;
  assign dp_mul_int32 = fixed_en ? fixed_val        : {dp_a, dp_b};
  assign dp_sum_int16 = fixed_en ? fixed_val[32:0]  : ({1'b0, dp_a} + {1'b0, dp_b});
  assign dp_sum_int8  = fixed_en ? fixed_val[17:0]  : (dp_a[17:0] ^ dp_b[17:0]);
  assign dp_sum_int4  = fixed_en ? fixed_val[10:0]  : dp_a[10:0];
  assign dp_sum_int2  = fixed_en ? fixed_val[7:0]   : dp_b[7:0];

  dp_seq_ctrl #(.ACC_W(72), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .dp_a(dp_a), .dp_b(dp_b),
    .dp_mul_int32(dp_mul_int32), .dp_sum_int16(dp_sum_int16), .dp_sum_int8(dp_sum_int8),
    .dp_sum_int4(dp_sum_int4), .dp_sum_int2(dp_sum_int2),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out", name);
  endtask

  // Per-pair contribution as the spec defines it: the mode-matching dp32 output, zero-extended.
  function automatic logic [63:0] addend(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    case (m)
      3'd0:    return fixed_en ? 64'(fixed_val[7:0])  : 64'(b[7:0]);
      3'd1:    return fixed_en ? 64'(fixed_val[10:0]) : 64'(a[10:0]);
      3'd2:    return fixed_en ? 64'(fixed_val[17:0]) : 64'(a[17:0] ^ b[17:0]);
      3'd3:    return fixed_en ? 64'(fixed_val[32:0]) : (64'(a) + 64'(b));
      3'd4:    return fixed_en ? fixed_val : {a, b};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [71:0] acc_sum(input logic [71:0] acc, input logic [63:0] add);
    logic [72:0] s;
    s = {1'b0, acc} + 73'(add);
`ifdef DP_SEQ_SAT_EN
    if (s[72]) return {72{1'b1}};
`endif
    return s[71:0];
  endfunction

  function automatic bit acc_ovf(input logic [71:0] acc, input logic [63:0] add);
    logic [72:0] s;
    s = {1'b0, acc} + 73'(add);
`ifdef DP_SEQ_SAT_EN
    return s[72];
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: tracks who may hand over what, and when the result is due.
  int          cyc = 0;
  bit          m_idle = 1, m_resv = 0, m_err = 0, m_sat = 0;
  int          m_left = 0, m_rise = -1;
  logic [2:0]  m_mode = 3'd0;
  logic [71:0] m_exp = 72'd0;
  logic [31:0] m_dpa = 32'd0, m_dpb = 32'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1; m_resv <= 0; m_err <= 0; m_sat <= 0;
      m_left <= 0; m_rise <= -1; m_mode <= 3'd0; m_exp <= 72'd0;
      m_dpa <= 32'd0; m_dpb <= 32'd0;
    end else begin
      cyc <= cyc + 1;
      if (m_idle && cmd_valid) begin
        m_idle <= 0;
        m_exp  <= 72'd0;
        m_sat  <= 0;
        m_mode <= cmd_mode;
        m_err  <= (cmd_mode > 3'd4);
        if (cmd_mode <= 3'd4 && cmd_len != 16'd0) m_left <= int'(cmd_len);
        else m_rise <= cyc + 2;
      end
      if (m_left > 0 && op_valid) begin
        m_exp  <= acc_sum(m_exp, addend(m_mode, op_a, op_b));
        m_sat  <= m_sat | acc_ovf(m_exp, addend(m_mode, op_a, op_b));
        m_dpa  <= op_a;
        m_dpb  <= op_b;
        m_left <= m_left - 1;
        if (m_left == 1) m_rise <= cyc + 3;
      end
      if (m_resv && res_ready) begin
        m_resv <= 0;
        m_idle <= 1;
        m_rise <= -1;
      end else if (!m_idle && (cyc + 1) == m_rise) begin
        m_resv <= 1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("cmd_ready", 72'(cmd_ready), 72'(m_idle));
      chk("op_ready", 72'(op_ready), 72'(m_left > 0));
      chk("busy", 72'(busy), 72'(!m_idle));
      chk("res_valid", 72'(res_valid), 72'(m_resv));
      chk("dp_a", 72'(dp_a), 72'(m_dpa));
      chk("dp_b", 72'(dp_b), 72'(m_dpb));
      if (m_resv) begin
        chk("res_data", res_data, m_exp);
        chk("res_err", 72'(res_err), 72'(m_err | m_sat));
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_cmd_ready"}, 72'(cmd_ready), 72'd1);
    chk({tag, "_op_ready"}, 72'(op_ready), 72'd0);
    chk({tag, "_busy"}, 72'(busy), 72'd0);
    chk({tag, "_res_valid"}, 72'(res_valid), 72'd0);
    chk({tag, "_res_err"}, 72'(res_err), 72'd0);
    chk({tag, "_res_data"}, res_data, 72'd0);
    chk({tag, "_dp_a"}, 72'(dp_a), 72'd0);
    chk({tag, "_dp_b"}, 72'(dp_b), 72'd0);
  endtask

  // One command: issue, stream pairs (vmode 0=always,1=toggle,2=random), collect result.
  task automatic run_vec(input logic [2:0] mode, input logic [15:0] len, input int vmode,
                         input int rdelay, input int abort_at,
                         output logic [71:0] data, output logic err, output int lat,
                         output int n_acc, output int n_rdy, output int stable_bad);
    int ref_edge, waited, k;
    bit seen, done;
    logic [71:0] held;
    n_acc = 0; n_rdy = 0; lat = -1; stable_bad = 0; seen = 0; done = 0;
    waited = 0; data = 72'd0; err = 1'b0; held = 72'd0;
    cmd_mode = mode; cmd_len = len; cmd_valid = 1'b1; res_ready = 1'b0; op_valid = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (k == 50) begin
      note_timeout("cmd_accept");
      cmd_valid = 1'b0;
      return;
    end
    ref_edge = cyc + 1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    cmd_mode = 3'($urandom);
    cmd_len = 16'($urandom);
    for (k = 0; k < 400 && !done; k++) begin
      case (vmode)
        0:       op_valid = 1'b1;
        1:       op_valid = (k % 2 == 0);
        default: op_valid = 1'($urandom_range(0, 1));
      endcase
      op_a = $urandom;
      op_b = $urandom;
      res_ready = seen && (waited > rdelay);
      @(negedge clk);
      if (op_ready) n_rdy++;
      if (op_valid && op_ready) begin
        n_acc++;
        ref_edge = cyc + 1;
      end
      if (res_valid) begin
        if (!seen) begin
          seen = 1;
          lat = cyc - ref_edge;
          held = res_data;
        end else if (res_data !== held || cmd_ready !== 1'b0) begin
          stable_bad++;
        end
        if (res_ready) begin
          data = res_data;
          err = res_err;
          done = 1;
        end else begin
          waited++;
        end
      end
      if (abort_at > 0 && n_acc == abort_at) begin
        @(posedge clk); #3;
        op_valid = 1'b0;
        rst = 1'b1;
        #1;
        reset_checks("midrun_rst");
        @(posedge clk); #2;
        rst = 1'b0;
        return;
      end
      @(posedge clk); #2;
    end
    res_ready = 1'b0;
    op_valid = 1'b0;
    if (!done) note_timeout("result");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] d;
    logic e;
    int lat, na, nr, sb;
    rst = 1'b0; cmd_valid = 1'b0; cmd_mode = 3'd0; cmd_len = 16'd0;
    op_valid = 1'b0; op_a = 32'd0; op_b = 32'd0; res_ready = 1'b0;
    #1 rst = 1'b1;
    #1 reset_checks("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // int8, N=3, constant 100
    fixed_en = 1; fixed_val = 64'd100;
    run_vec(3'd2, 16'd3, 0, 0, 0, d, e, lat, na, nr, sb);
    chk("int8_data", d, 72'd300);
    chk("int8_err", 72'(e), 72'd0);
    chk("int8_latency", 72'(lat), 72'd2);
    chk("int8_op_ready_cycles", 72'(nr), 72'd3);
    chk("int8_accepts", 72'(na), 72'd3);

    // int32, N=2, all-ones product: no wrap in 72 bits
    fixed_val = 64'hFFFF_FFFF_FFFF_FFFF;
    run_vec(3'd4, 16'd2, 0, 1, 0, d, e, lat, na, nr, sb);
    chk("int32_data", d, 72'h1_FFFF_FFFF_FFFF_FFFE);
    chk("int32_err", 72'(e), 72'd0);

    // illegal mode, len 5
    run_vec(3'd6, 16'd5, 0, 0, 0, d, e, lat, na, nr, sb);
    chk("illegal_data", d, 72'd0);
    chk("illegal_err", 72'(e), 72'd1);
    chk("illegal_op_ready_cycles", 72'(nr), 72'd0);
    chk("illegal_latency", 72'(lat), 72'd1);

    // int4, len 0
    run_vec(3'd1, 16'd0, 0, 0, 0, d, e, lat, na, nr, sb);
    chk("len0_data", d, 72'd0);
    chk("len0_err", 72'(e), 72'd0);
    chk("len0_latency", 72'(lat), 72'd1);

    // int4, N=4, toggling op_valid, consumer stalls 5 cycles
    fixed_val = 64'd7;
    run_vec(3'd1, 16'd4, 1, 5, 0, d, e, lat, na, nr, sb);
    chk("int4_accepts", 72'(na), 72'd4);
    chk("int4_data", d, 72'd28);
    chk("int4_stall_stable", 72'(sb), 72'd0);

    // reset after 2 of 4 accepts, then a fresh int2 N=1 vector
    run_vec(3'd1, 16'd4, 0, 0, 2, d, e, lat, na, nr, sb);
    fixed_val = 64'd9;
    run_vec(3'd0, 16'd1, 0, 0, 0, d, e, lat, na, nr, sb);
    chk("post_reset_data", d, 72'd9);
    chk("post_reset_err", 72'(e), 72'd0);

    // randomized vectors, stub outputs depend on the operands
    fixed_en = 0;
    for (int i = 0; i < 30; i++) begin
      run_vec(3'($urandom_range(0, 7)), 16'($urandom_range(0, 12)), $urandom_range(0, 2),
              $urandom_range(0, 3), 0, d, e, lat, na, nr, sb);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
